// File: rtl/single_dot_v_m_arbiter.sv
// Round-robin arbiter that shares one single_dot_v_m engine among NUM_REQ requesters.
// Optional engine watchdog: define SINGLE_DOT_ARB_TIMEOUT_EN (adds the timeout_err port).
module single_dot_v_m_arbiter #(
   parameter int unsigned WIDTH          = 5,
   parameter int unsigned HEIGHT         = 5,
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ*WIDTH*32-1:0]        req_vector,
   input  logic [NUM_REQ*WIDTH*HEIGHT*32-1:0] req_matrix,
   output logic [NUM_REQ-1:0]                 ack,
   output logic [NUM_REQ-1:0]                 resp_valid,
   output logic [HEIGHT*32-1:0]               result,
   output logic                               busy,
   output logic                               engine_start,
   output logic [WIDTH*32-1:0]                engine_vector,
   output logic [WIDTH*HEIGHT*32-1:0]         engine_matrix,
   input  logic                               engine_done,
   input  logic [HEIGHT*32-1:0]               engine_vector_out
`ifdef SINGLE_DOT_ARB_TIMEOUT_EN
   ,
   output logic                               timeout_err
`endif
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("single_dot_v_m_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   state_e                      state_q, state_d;
   logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]            g_q, g_d;
   logic [NUM_REQ-1:0]          ack_q, ack_d;
   logic [NUM_REQ-1:0]          resp_valid_q, resp_valid_d;
   logic [HEIGHT*32-1:0]        result_q, result_d;
   logic                        start_q, start_d;
   logic [WIDTH*32-1:0]         vec_q, vec_d;
   logic [WIDTH*HEIGHT*32-1:0]  mat_q, mat_d;
`ifdef SINGLE_DOT_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        tmo_q, tmo_d;
`endif

   logic [WIDTH*32-1:0]         vec_slice [NUM_REQ];
   logic [WIDTH*HEIGHT*32-1:0]  mat_slice [NUM_REQ];
   logic                        found;
   logic [PTR_W-1:0]            grant_idx;
   logic [31:0]                 cand;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign vec_slice[i] = req_vector[i*WIDTH*32 +: WIDTH*32];
      assign mat_slice[i] = req_matrix[i*WIDTH*HEIGHT*32 +: WIDTH*HEIGHT*32];
   end

   // First set request at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && req[cand[PTR_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      g_d          = g_q;
      ack_d        = '0;
      resp_valid_d = '0;
      result_d     = result_q;
      start_d      = 1'b0;
      vec_d        = vec_q;
      mat_d        = mat_q;
`ifdef SINGLE_DOT_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
      tmo_d        = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               g_d     = grant_idx;
               ack_d   = NUM_REQ'(1) << grant_idx;
               start_d = 1'b1;
               vec_d   = vec_slice[grant_idx];
               mat_d   = mat_slice[grant_idx];
               state_d = ST_WAIT;
`ifdef SINGLE_DOT_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ST_WAIT: begin
            if (engine_done) begin
               result_d     = engine_vector_out;
               resp_valid_d = NUM_REQ'(1) << g_q;
               state_d      = ST_RESP;
            end
`ifdef SINGLE_DOT_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               result_d     = '1;
               resp_valid_d = NUM_REQ'(1) << g_q;
               tmo_d        = 1'b1;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_RESP: begin
            rr_ptr_d = (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + PTR_W'(1);
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         g_q          <= '0;
         ack_q        <= '0;
         resp_valid_q <= '0;
         result_q     <= '0;
         start_q      <= 1'b0;
         vec_q        <= '0;
         mat_q        <= '0;
`ifdef SINGLE_DOT_ARB_TIMEOUT_EN
         cnt_q        <= '0;
         tmo_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         g_q          <= g_d;
         ack_q        <= ack_d;
         resp_valid_q <= resp_valid_d;
         result_q     <= result_d;
         start_q      <= start_d;
         vec_q        <= vec_d;
         mat_q        <= mat_d;
`ifdef SINGLE_DOT_ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
`endif
      end
   end

   assign ack           = ack_q;
   assign resp_valid    = resp_valid_q;
   assign result        = result_q;
   assign busy          = (state_q != ST_IDLE);
   assign engine_start  = start_q;
   assign engine_vector = vec_q;
   assign engine_matrix = mat_q;
`ifdef SINGLE_DOT_ARB_TIMEOUT_EN
   assign timeout_err   = tmo_q;
`endif

endmodule
